mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter: TIMEOUT, default 8'd200, ACCESS cycles without mem_ready before abort (1..255).
REQ-002 The block SHALL have port: clk  input  1  system clock; all state updates on the negative edge.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: req  input  3  request per requester; bit0 command fetch (read), bit1 operand read, bit2 writeback (write).
REQ-005 The block SHALL have ports: addr0, addr1, addr2  input  32 each  address per requester.
REQ-006 The block SHALL have port: wdata2  input  32  writeback data.
REQ-007 The block SHALL have port: gnt  output  3  one-hot current owner, all-zero when idle.
REQ-008 The block SHALL have port: ack  output  3  one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port: err  output  1  one-cycle pulse, coincident with ack, on timeout.
REQ-010 The block SHALL have port: rdata  output  32  read data, valid while ack is high.
REQ-011 The block SHALL have ports: mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-012 The block SHALL have ports: mem_rd, mem_wr  output  1 each  memory read and write strobes.
REQ-013 The block SHALL have port: mem_ready  input  1  memory completion, sampled during ACCESS.
REQ-014 The block SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-016 IDLE: if req!=0, the block SHALL latch the winner into gnt, load mem_addr (plus mem_wdata for bit2), assert mem_rd (bit0/1) or mem_wr (bit2), clear the timeout counter and enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 ACCESS: the block SHALL hold mem_addr, mem_wdata, mem_rd, mem_wr and gnt stable.
REQ-018 ACCESS: on mem_ready=1, the block SHALL capture read data into rdata (reads only), drop the strobes and enter DONE with ack[owner]=1.
REQ-019 ACCESS timeout: if the counter reaches TIMEOUT with mem_ready=0, the block SHALL drop the strobes, set rdata=0, enter DONE and assert ack[owner] and err together.
REQ-020 DONE: the block SHALL hold ack/err for exactly one cycle, clear gnt and return to IDLE.
REQ-021 Minimum latency: req high before edge N, strobe from edge N, mem_ready high at edge N+1, ack high from edge N+2 to N+3.
REQ-022 Back-to-back: there SHALL be one IDLE cycle minimum between accesses; there is no zero-gap re-grant.
REQ-023 A requester SHALL hold req, address and data until its ack; dropping req mid-ACCESS SHALL NOT abort the access, and ack is still pulsed.
REQ-024 The block SHALL ignore mem_ready outside ACCESS.
REQ-025 The block SHALL NOT issue ack to a non-owner, and ack SHALL never have more than one bit set.
REQ-026 The timeout counter SHALL be 8 bits wide, saturate at TIMEOUT, and never wrap.

Reset
REQ-027 rst=0 SHALL immediately force IDLE and zero gnt, ack, err, busy, rdata, mem_addr, mem_wdata, mem_rd, mem_wr and the counter, regardless of clk.
REQ-028 An access in progress at reset SHALL be abandoned with no ack; requesters re-request after reset.
REQ-029 The round-robin pointer SHALL reset to "last granted = bit2", so bit0 has top priority first.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: priority SHALL rotate, starting from the bit after the last granted requester (0->1->2->0).
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority bit2 > bit1 > bit0 SHALL apply, and the pointer SHALL be absent.

Verification
REQ-032 Single read: req=001, addr0=0x100, mem_ready high on first ACCESS cycle -> mem_rd one cycle, ack=001 at N+2, rdata=mem value.
REQ-033 Write with 3 wait states: req=100, addr2=0x20, wdata2=0xDEADBEEF, mem_ready after 3 cycles -> mem_wr held 4 cycles, ack=100, err=0.
REQ-034 Contention: req=111 held, instant mem_ready -> with macro, grants 001,010,100,001; without macro, grant 100 repeatedly.
REQ-035 Timeout: TIMEOUT=5, mem_ready stuck 0 -> after 5 ACCESS cycles, ack=010, err=1, rdata=0, then IDLE.
REQ-036 Reset mid-ACCESS: rst=0 between edges -> all outputs 0 at once, no ack; after release, req=010 is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates three requesters onto one memory port.
//   req[0] command fetch (read), req[1] operand read, req[2] writeback (write).
//   All state updates happen on the falling edge of clk; rst is asynchronous, active-low.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> rotating priority, starting after the last granted requester
//   undefined -> fixed priority req[2] > req[1] > req[0], no pointer
//
// Ports
//   clk, rst                  clock (negedge active), async active-low reset
//   req[2:0]                  request per requester
//   addr0/addr1/addr2         address per requester
//   wdata2                    writeback data
//   gnt[2:0]                  one-hot owner, zero when idle
//   ack[2:0], err             one-cycle completion pulse (err on timeout)
//   rdata                     read data, valid while ack is high
//   mem_addr, mem_wdata       memory address / write data
//   mem_rd, mem_wr            memory strobes
//   mem_rdata, mem_ready      memory read data / completion
//   busy                      high whenever not IDLE
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata2,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [8:0]  cnt_inc;
  // fin marks the cycle after the memory finished (or timed out): strobes are
  // already low, and the ack is issued on the next edge as DONE is entered.
  logic        fin, fin_nxt;
  logic        fin_err, fin_err_nxt;
  logic [2:0]  gnt_nxt, ack_nxt, win;
  logic        err_nxt, rd_nxt, wr_nxt;
  logic [31:0] rdata_nxt, addr_nxt, wdata_nxt;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last, last_nxt;

  // Scan from the farthest candidate to the nearest so the requester right
  // after the last owner wins.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] last_idx);
    logic [2:0] g;
    logic [1:0] idx;
    g = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(last_idx) + i) % 3);
      if (r[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  assign win = pick(req, last);
`else
  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  assign win = pick(req);
`endif

  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fin_nxt     = fin;
    fin_err_nxt = fin_err;
    gnt_nxt     = gnt;
    ack_nxt     = 3'b000;
    err_nxt     = 1'b0;
    rdata_nxt   = rdata;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    rd_nxt      = mem_rd;
    wr_nxt      = mem_wr;
`ifdef ARB_ROUND_ROBIN_EN
    last_nxt    = last;
`endif
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_nxt     = win;
          cnt_nxt     = 8'd0;
          fin_nxt     = 1'b0;
          fin_err_nxt = 1'b0;
          state_nxt   = ACCESS;
          if (win[2]) begin
            addr_nxt  = addr2;
            wdata_nxt = wdata2;
            rd_nxt    = 1'b0;
            wr_nxt    = 1'b1;
          end else begin
            addr_nxt  = win[1] ? addr1 : addr0;
            rd_nxt    = 1'b1;
            wr_nxt    = 1'b0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_nxt = win[2] ? 2'd2 : (win[1] ? 2'd1 : 2'd0);
`endif
        end
      end
      ACCESS: begin
        if (fin) begin
          state_nxt = DONE;
          ack_nxt   = gnt;
          err_nxt   = fin_err;
        end else if (mem_ready) begin
          if (mem_rd) rdata_nxt = mem_rdata;
          rd_nxt  = 1'b0;
          wr_nxt  = 1'b0;
          fin_nxt = 1'b1;
        end else if (cnt_inc >= {1'b0, TIMEOUT}) begin
          // Counter saturates at TIMEOUT; it is only reloaded on a new grant.
          cnt_nxt     = TIMEOUT;
          rdata_nxt   = 32'd0;
          rd_nxt      = 1'b0;
          wr_nxt      = 1'b0;
          fin_nxt     = 1'b1;
          fin_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[7:0];
        end
      end
      DONE: begin
        gnt_nxt   = 3'b000;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      fin       <= 1'b0;
      fin_err   <= 1'b0;
      gnt       <= 3'b000;
      ack       <= 3'b000;
      err       <= 1'b0;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 2'd2;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fin       <= fin_nxt;
      fin_err   <= fin_err_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_rd    <= rd_nxt;
      mem_wr    <= wr_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: the bench plays requesters and memory, predicts
// each transaction as a timeline (strobe length from the wait-state count,
// one finishing cycle, one ack cycle, back to idle) and compares every cycle.
module tb_mem_arbiter;
  localparam logic [7:0] TB_TIMEOUT = 8'd5;
  localparam int         TO         = 5;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] addr0, addr1, addr2, wdata2;
  logic [2:0]  gnt, ack;
  logic        err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready, busy;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic [2:0]  exp_gnt, exp_ack;
  logic        exp_err, exp_rd, exp_wr, exp_busy;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  int          last_idx;
  logic [31:0] m_rdata;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .wdata2(wdata2),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Outputs settle after the falling edge; compare on the rising edge.
  always @(posedge clk) begin
    if (chk_en) begin
      check("gnt",    32'(gnt),    32'(exp_gnt));
      check("ack",    32'(ack),    32'(exp_ack));
      check("err",    32'(err),    32'(exp_err));
      check("busy",   32'(busy),   32'(exp_busy));
      check("mem_rd", 32'(mem_rd), 32'(exp_rd));
      check("mem_wr", 32'(mem_wr), 32'(exp_wr));
      if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_addr);
      if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
      if (exp_ack != 3'b000 && (!exp_ack[2] || exp_err)) check("rdata", rdata, exp_rdata);
    end
  end

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_gnt  = 3'b000;
    exp_ack  = 3'b000;
    exp_err  = 1'b0;
    exp_rd   = 1'b0;
    exp_wr   = 1'b0;
    exp_busy = 1'b0;
  endtask

  function automatic logic [2:0] model_pick(input logic [2:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last_idx + k) % 3;
      if (r[i]) return 3'b001 << i;
    end
    return 3'b000;
`else
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      slot();
      req       = 3'b000;
      mem_ready = 1'($urandom);
    end
  endtask

  // One transaction starting at an IDLE edge. w = wait states before
  // mem_ready (w >= TO means it never comes). mode: 0 owner holds req and
  // others toggle, 1 owner drops req during the access, 2 req held at r.
  task automatic txn(input logic [2:0] r, input int w, input int mode, input logic [31:0] rd_val,
                     output logic [2:0] won, output int len, output logic was_err);
    logic [2:0]  win;
    logic [31:0] a;
    int          L;
    logic        to;
    win = model_pick(r);
    L   = (w < TO) ? w + 1 : TO;
    to  = (w >= TO);
    a   = win[2] ? addr2 : (win[1] ? addr1 : addr0);
    slot();
    req       = r;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    exp_gnt   = win;
    exp_rd    = ~win[2];
    exp_wr    = win[2];
    exp_busy  = 1'b1;
    exp_addr  = a;
    exp_wdata = wdata2;
    exp_ack   = 3'b000;
    exp_err   = 1'b0;
    for (int j = 1; j <= L; j++) begin
      slot();
      case (mode)
        0:       req = 3'($urandom) | win;
        1:       req = 3'($urandom) & ~win;
        default: req = r;
      endcase
      mem_ready = (j == w + 1);
      mem_rdata = (j == w + 1) ? rd_val : $urandom;
      if (j == L) begin
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (to) m_rdata = 32'd0;
        else if (!win[2]) m_rdata = mem_rdata;
      end
    end
    slot();
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    if (mode != 2) req = 3'($urandom);
    exp_ack   = win;
    exp_err   = to;
    exp_rdata = m_rdata;
    slot();
    mem_ready = 1'($urandom);
    if (mode != 2) req = 3'($urandom);
    exp_idle();
    last_idx = win[2] ? 2 : (win[1] ? 1 : 0);
    won     = win;
    len     = L;
    was_err = to;
  endtask

  initial begin
    logic [2:0] won;
    int         len;
    logic       e;
    logic [2:0] got [4];
    logic [2:0] want_seq [4];
`ifdef ARB_ROUND_ROBIN_EN
    want_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    want_seq = '{3'b100, 3'b100, 3'b100, 3'b100};
`endif
    rst = 1'b1; req = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0; wdata2 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_idle(); exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
    last_idx = 2; m_rdata = '0;

    // Reset asserted away from any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),   32'd0);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_rdata", rdata,      32'd0);
    check("rst_addr",  mem_addr,   32'd0);
    check("rst_wdata", mem_wdata,  32'd0);
    check("rst_strb",  32'({mem_rd, mem_wr, err}), 32'd0);
    chk_en = 1'b1;
    slot(); slot();
    rst = 1'b1;
    idle(2);

    // Single read with no wait state.
    addr0 = 32'h0000_0100;
    txn(3'b001, 0, 2, 32'h1234_5678, won, len, e);
    check("read_win",   32'(won), 32'h1);
    check("read_len",   32'(len), 32'd1);
    check("read_err",   32'(e),   32'd0);
    check("read_rdata", m_rdata,  32'h1234_5678);

    // Write with three wait states.
    addr2 = 32'h0000_0020; wdata2 = 32'hDEAD_BEEF;
    txn(3'b100, 3, 2, 32'h0, won, len, e);
    check("write_win", 32'(won), 32'h4);
    check("write_len", 32'(len), 32'd4);
    check("write_err", 32'(e),   32'd0);

    // Contention with all three requesting.
    addr0 = 32'hA0; addr1 = 32'hA1; addr2 = 32'hA2;
    for (int k = 0; k < 4; k++) begin
      txn(3'b111, 0, 2, $urandom, won, len, e);
      got[k] = won;
    end
    for (int k = 0; k < 4; k++) check($sformatf("contend_%0d", k), 32'(got[k]), 32'(want_seq[k]));

    // Timeout: mem_ready never arrives.
    addr1 = 32'h0000_0300;
    txn(3'b010, 255, 2, 32'hFFFF_FFFF, won, len, e);
    check("to_win",   32'(won), 32'h2);
    check("to_len",   32'(len), 32'd5);
    check("to_err",   32'(e),   32'd1);
    check("to_rdata", m_rdata,  32'd0);
    idle(1);

    // Reset in the middle of an access.
    addr0 = 32'h0000_0500;
    slot();
    req = 3'b001; mem_ready = 1'b0;
    exp_gnt = model_pick(3'b001); exp_rd = 1'b1; exp_wr = 1'b0;
    exp_busy = 1'b1; exp_addr = addr0;
    slot();
    mem_ready = 1'b0;
    slot();
    rst = 1'b0;
    #1;
    check("mid_rst_gnt",  32'(gnt),  32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd",   32'(mem_rd), 32'd0);
    check("mid_rst_addr", mem_addr,  32'd0);
    check("mid_rst_ack",  32'(ack),  32'd0);
    exp_idle(); m_rdata = '0; last_idx = 2;
    slot();
    mem_ready = 1'b1;
    slot();
    rst = 1'b1; req = 3'b000;
    idle(1);
    addr1 = 32'h0000_0610;
    txn(3'b010, 1, 0, 32'hCAFE_F00D, won, len, e);
    check("post_rst_win",   32'(won), 32'h2);
    check("post_rst_rdata", m_rdata,  32'hCAFE_F00D);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      addr0 = $urandom; addr1 = $urandom; addr2 = $urandom; wdata2 = $urandom;
      txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
          $urandom, won, len, e);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
